// File: rtl/coldstore_pkg.sv
// coldstore_pkg: shared command encodings, reset thresholds and actuator state type.
package coldstore_pkg;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_B = 8'h42;
    localparam logic [7:0] ASCII_C = 8'h43;
    localparam logic [7:0] ASCII_D = 8'h44;
    localparam logic [7:0] ASCII_L = 8'h4C;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_1 = 8'h31;
    localparam logic [7:0] ASCII_9 = 8'h39;
    localparam logic [7:0] CMD_MAX_TEMP = ASCII_A;
    localparam logic [7:0] CMD_MIN_TEMP = ASCII_B;
    localparam logic [7:0] CMD_MAX_HUM = ASCII_C;
    localparam logic [7:0] CMD_MIN_HUM = ASCII_D;
    localparam logic [7:0] CMD_MANUAL = ASCII_L;
    localparam logic [6:0] RST_MAX_TEMP = 7'd30;
    localparam logic [6:0] RST_MIN_TEMP = 7'd20;
    localparam logic [6:0] RST_MAX_HUM = 7'd70;
    localparam logic [6:0] RST_MIN_HUM = 7'd40;
    typedef enum logic {ACT_OFF, ACT_ON} act_st_e;
    function automatic logic is_digit(input logic [7:0] c);
        return c >= ASCII_0 && c <= ASCII_9;
    endfunction
    function automatic logic is_bit(input logic [7:0] c);
        return c == ASCII_0 || c == ASCII_1;
    endfunction
endpackage

// File: rtl/coldstore_ctrl_sec_tick_gen.sv
// sec_tick_gen: free-running counter emitting a one-cycle tick every TICK_CYCLES clocks.
module sec_tick_gen #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk_100Mhz,
    input  logic rst,
    output logic tick
);
    localparam int W = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(TICK_CYCLES - 1);
    always_ff @(posedge clk_100Mhz) begin
        cnt <= rst || tick ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/coldstore_ctrl.sv
// coldstore_ctrl: command decode, threshold store and hysteretic fan/humidifier control.
// Define COLDSTORE_DWELL_EN to enforce a minimum dwell between automatic actuator changes.
module coldstore_ctrl
    import coldstore_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int DWELL_SECS = 5,
    parameter int MANUAL_SECS = 60,
    parameter logic [6:0] DEF_MAX_TEMP = RST_MAX_TEMP,
    parameter logic [6:0] DEF_MIN_TEMP = RST_MIN_TEMP,
    parameter logic [6:0] DEF_MAX_HUM = RST_MAX_HUM,
    parameter logic [6:0] DEF_MIN_HUM = RST_MIN_HUM
) (
    input  logic       clk_100Mhz,
    input  logic       rst,
    input  logic [7:0] chr_cmd,
    input  logic [7:0] chr_val0,
    input  logic [7:0] chr_val1,
    input  logic       rx_msg_done,
    input  logic [7:0] temperature,
    input  logic [7:0] humidity,
    output logic [6:0] max_temp,
    output logic [6:0] min_temp,
    output logic [6:0] max_hum,
    output logic [6:0] min_hum,
    output logic       fan_on,
    output logic       hum_on,
    output logic       manual_mode,
    output logic       cfg_err
);
    // One width shared by the manual and dwell second counters.
    localparam int SMAX = MANUAL_SECS > DWELL_SECS ? MANUAL_SECS : DWELL_SECS;
    localparam int CW = SMAX < 1 ? 1 : $clog2(SMAX + 1);
    logic tick, prev_done, acc, d_ok, l_acc, rej;
    logic wr_a, wr_b, wr_c, wr_d, fan_ok, hum_ok;
    logic [7:0] v;
    logic [CW-1:0] man_cnt;
    act_st_e fan_st, fan_nx, hum_st, hum_nx;

    sec_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk_100Mhz(clk_100Mhz),
        .rst(rst),
        .tick(tick)
    );

    assign acc = rx_msg_done & ~prev_done;
    assign d_ok = is_digit(chr_val0) & is_digit(chr_val1);
    assign v = (chr_val0 - ASCII_0) * 8'd10 + (chr_val1 - ASCII_0);
    assign wr_a = acc && chr_cmd == CMD_MAX_TEMP && d_ok && v > {1'b0, min_temp};
    assign wr_b = acc && chr_cmd == CMD_MIN_TEMP && d_ok && v < {1'b0, max_temp};
    assign wr_c = acc && chr_cmd == CMD_MAX_HUM && d_ok && v > {1'b0, min_hum};
    assign wr_d = acc && chr_cmd == CMD_MIN_HUM && d_ok && v < {1'b0, max_hum};
    assign l_acc = acc && chr_cmd == CMD_MANUAL && is_bit(chr_val0) && is_bit(chr_val1);
    assign rej = acc & ~(wr_a | wr_b | wr_c | wr_d | l_acc);
    assign fan_on = fan_st == ACT_ON;
    assign hum_on = hum_st == ACT_ON;

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            max_temp <= DEF_MAX_TEMP;
            min_temp <= DEF_MIN_TEMP;
            max_hum <= DEF_MAX_HUM;
            min_hum <= DEF_MIN_HUM;
            prev_done <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            prev_done <= rx_msg_done;
            cfg_err <= rej;
            if (wr_a) max_temp <= v[6:0];
            if (wr_b) min_temp <= v[6:0];
            if (wr_c) max_hum <= v[6:0];
            if (wr_d) min_hum <= v[6:0];
        end
    end

    // A fresh 'L' reloads the counter, so a coincident tick is ignored.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            manual_mode <= 1'b0;
            man_cnt <= '0;
        end else if (l_acc) begin
            manual_mode <= 1'b1;
            man_cnt <= CW'(MANUAL_SECS);
        end else if (manual_mode && tick) begin
            manual_mode <= man_cnt > CW'(1);
            man_cnt <= man_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        fan_st <= rst ? ACT_OFF : fan_nx;
        hum_st <= rst ? ACT_OFF : hum_nx;
    end

    always_comb begin
        fan_nx = fan_st;
        hum_nx = hum_st;
        if (l_acc) begin
            fan_nx = chr_val0[0] ? ACT_ON : ACT_OFF;
            hum_nx = chr_val1[0] ? ACT_ON : ACT_OFF;
        end else if (!manual_mode) begin
            if (fan_ok)
                fan_nx = fan_st == ACT_OFF ? (temperature > {1'b0, max_temp} ? ACT_ON : ACT_OFF)
                                           : (temperature < {1'b0, min_temp} ? ACT_OFF : ACT_ON);
            if (hum_ok)
                hum_nx = hum_st == ACT_OFF ? (humidity < {1'b0, min_hum} ? ACT_ON : ACT_OFF)
                                           : (humidity > {1'b0, max_hum} ? ACT_OFF : ACT_ON);
        end
    end

`ifdef COLDSTORE_DWELL_EN
    logic [CW-1:0] fan_dw, hum_dw;
    assign fan_ok = fan_dw == '0;
    assign hum_ok = hum_dw == '0;
    always_ff @(posedge clk_100Mhz) begin
        if (rst || l_acc) begin
            fan_dw <= '0;
            hum_dw <= '0;
        end else begin
            fan_dw <= fan_nx != fan_st ? CW'(DWELL_SECS) : fan_dw - CW'(tick && fan_dw != '0);
            hum_dw <= hum_nx != hum_st ? CW'(DWELL_SECS) : hum_dw - CW'(tick && hum_dw != '0);
        end
    end
`else
    assign fan_ok = 1'b1;
    assign hum_ok = 1'b1;
`endif
endmodule

// File: tb/tb_coldstore_ctrl.sv
// tb_coldstore_ctrl: table-driven command checks, directed corner sequences and a
// randomized run compared every cycle against a behavioural model.
module tb_coldstore_ctrl;
    localparam int T = 4;
    localparam int DW = 3;
    localparam int MS = 5;
`ifdef COLDSTORE_DWELL_EN
    localparam bit DW_EN = 1'b1;
`else
    localparam bit DW_EN = 1'b0;
`endif

    logic clk_100Mhz = 1'b0;
    logic rst = 1'b1;
    logic rx_msg_done = 1'b0;
    logic [7:0] chr_cmd = "A", chr_val0 = "0", chr_val1 = "0";
    logic [7:0] temperature = 8'd25, humidity = 8'd55;
    logic [6:0] max_temp, min_temp, max_hum, min_hum;
    logic fan_on, hum_on, manual_mode, cfg_err;
    int checks = 0, errors = 0;

    int m_mt, m_nt, m_mh, m_nh, m_fan, m_hum, m_man, m_mcnt, m_fdw, m_hdw, m_prev, m_tcnt, m_err;

    typedef struct {
        logic [7:0] cmd, v0, v1;
        int err, mt, nt, mh, nh;
    } vec_t;
    vec_t tbl[20];

    always #5 clk_100Mhz = ~clk_100Mhz;

    coldstore_ctrl #(.TICK_CYCLES(T), .DWELL_SECS(DW), .MANUAL_SECS(MS)) dut (
        .clk_100Mhz(clk_100Mhz), .rst(rst), .chr_cmd(chr_cmd), .chr_val0(chr_val0),
        .chr_val1(chr_val1), .rx_msg_done(rx_msg_done), .temperature(temperature),
        .humidity(humidity), .max_temp(max_temp), .min_temp(min_temp), .max_hum(max_hum),
        .min_hum(min_hum), .fan_on(fan_on), .hum_on(hum_on), .manual_mode(manual_mode),
        .cfg_err(cfg_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next-state of the whole block from the rules, using the inputs about to be sampled.
    task automatic model_step();
        int c0, c1, v, o_mt, o_nt, o_mh, o_nh, o_man, o_fdw, o_hdw;
        bit tick, acc, dig, lacc, want;
        if (rst) begin
            {m_mt, m_nt, m_mh, m_nh} = {32'd30, 32'd20, 32'd70, 32'd40};
            {m_fan, m_hum, m_man, m_mcnt, m_fdw, m_hdw, m_prev, m_tcnt, m_err} = '0;
            return;
        end
        tick = m_tcnt == T - 1;
        m_tcnt = tick ? 0 : m_tcnt + 1;
        acc = rx_msg_done && m_prev == 0;
        m_prev = int'(rx_msg_done);
        c0 = int'(chr_val0);
        c1 = int'(chr_val1);
        dig = c0 >= 48 && c0 <= 57 && c1 >= 48 && c1 <= 57;
        v = (c0 - 48) * 10 + (c1 - 48);
        {o_mt, o_nt, o_mh, o_nh, o_man, o_fdw, o_hdw} = {m_mt, m_nt, m_mh, m_nh, m_man, m_fdw, m_hdw};
        lacc = 0;
        m_err = 0;
        if (acc) begin
            case (chr_cmd)
                "A": if (dig && v > o_nt) m_mt = v; else m_err = 1;
                "B": if (dig && v < o_mt) m_nt = v; else m_err = 1;
                "C": if (dig && v > o_nh) m_mh = v; else m_err = 1;
                "D": if (dig && v < o_mh) m_nh = v; else m_err = 1;
                "L": if ((c0 == 48 || c0 == 49) && (c1 == 48 || c1 == 49)) begin
                    lacc = 1;
                    m_fan = c0 - 48;
                    m_hum = c1 - 48;
                    m_man = 1;
                    m_mcnt = MS;
                    m_fdw = 0;
                    m_hdw = 0;
                end else m_err = 1;
                default: m_err = 1;
            endcase
        end
        if (!lacc && !o_man) begin
            want = m_fan ? !(int'(temperature) < o_nt) : int'(temperature) > o_mt;
            if ((!DW_EN || o_fdw == 0) && int'(want) != m_fan) begin
                m_fan = int'(want);
                m_fdw = DW;
            end else if (tick && m_fdw > 0) m_fdw--;
            want = m_hum ? !(int'(humidity) > o_mh) : int'(humidity) < o_nh;
            if ((!DW_EN || o_hdw == 0) && int'(want) != m_hum) begin
                m_hum = int'(want);
                m_hdw = DW;
            end else if (tick && m_hdw > 0) m_hdw--;
        end else if (!lacc && tick) begin
            m_mcnt--;
            if (m_mcnt == 0) m_man = 0;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk_100Mhz);
        #1;
        chk("max_temp", 32'(max_temp), m_mt);
        chk("min_temp", 32'(min_temp), m_nt);
        chk("max_hum", 32'(max_hum), m_mh);
        chk("min_hum", 32'(min_hum), m_nh);
        chk("fan_on", 32'(fan_on), m_fan);
        chk("hum_on", 32'(hum_on), m_hum);
        chk("manual_mode", 32'(manual_mode), m_man);
        chk("cfg_err", 32'(cfg_err), m_err);
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
        chr_cmd = c;
        chr_val0 = a;
        chr_val1 = b;
        rx_msg_done = 1'b1;
        cyc();
    endtask

    task automatic do_reset();
        rx_msg_done = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] cmds[6] = '{"A", "B", "C", "D", "L", "Z"};
        logic [7:0] vals[8] = '{"0", "1", "2", "4", "7", "9", "x", ":"};
        int n, pulses;
        tbl[0] = '{"A", "2", "5", 0, 25, 20, 70, 40};
        tbl[1] = '{"B", "2", "6", 1, 25, 20, 70, 40};
        tbl[2] = '{"B", "2", "4", 0, 25, 24, 70, 40};
        tbl[3] = '{"A", "2", "4", 1, 25, 24, 70, 40};
        tbl[4] = '{"C", "8", "0", 0, 25, 24, 80, 40};
        tbl[5] = '{"D", "4", "x", 1, 25, 24, 80, 40};
        tbl[6] = '{"Z", "1", "1", 1, 25, 24, 80, 40};
        tbl[7] = '{"D", "8", "0", 1, 25, 24, 80, 40};
        tbl[8] = '{"D", "7", "9", 0, 25, 24, 80, 79};
        tbl[9] = '{"C", "7", "9", 1, 25, 24, 80, 79};
        tbl[10] = '{"A", "9", "9", 0, 99, 24, 80, 79};
        tbl[11] = '{"L", "2", "0", 1, 99, 24, 80, 79};
        tbl[12] = '{"B", "/", "0", 1, 99, 24, 80, 79};
        tbl[13] = '{"C", ":", "0", 1, 99, 24, 80, 79};
        tbl[14] = '{"D", "0", "0", 0, 99, 24, 80, 0};
        tbl[15] = '{"B", "0", "0", 0, 99, 0, 80, 0};
        tbl[16] = '{"A", "3", "0", 0, 30, 0, 80, 0};
        tbl[17] = '{"B", "2", "0", 0, 30, 20, 80, 0};
        tbl[18] = '{"C", "7", "0", 0, 30, 20, 70, 0};
        tbl[19] = '{"D", "4", "0", 0, 30, 20, 70, 40};

        cyc();
        do_reset();
        chk("rst_max_temp", 32'(max_temp), 30);
        chk("rst_fan_on", 32'(fan_on), 0);
        for (int i = 0; i < 20; i++) begin
            send(tbl[i].cmd, tbl[i].v0, tbl[i].v1);
            chk($sformatf("tbl%0d_err", i), 32'(cfg_err), tbl[i].err);
            chk($sformatf("tbl%0d_mt", i), 32'(max_temp), tbl[i].mt);
            chk($sformatf("tbl%0d_nt", i), 32'(min_temp), tbl[i].nt);
            chk($sformatf("tbl%0d_mh", i), 32'(max_hum), tbl[i].mh);
            chk($sformatf("tbl%0d_nh", i), 32'(min_hum), tbl[i].nh);
            rx_msg_done = 1'b0;
            cyc();
            chk($sformatf("tbl%0d_err_clr", i), 32'(cfg_err), 0);
        end

        // Fan hysteresis with dwell
        do_reset();
        temperature = 8'd35;
        humidity = 8'd55;
        cyc();
        chk("fan_on_hot", 32'(fan_on), 1);
        temperature = 8'd19;
        n = 0;
        while (fan_on && n < 100) begin
            cyc();
            n++;
        end
        chk("fan_off_cold", 32'(fan_on), 0);
        if (DW_EN) chk("fan_dwell_held", 32'(n >= (DW - 1) * T), 1);

        // Manual override and timeout
        temperature = 8'd25;
        humidity = 8'd30;
        n = 0;
        while (!hum_on && n < 100) begin
            cyc();
            n++;
        end
        chk("hum_on_dry", 32'(hum_on), 1);
        send("L", "1", "0");
        rx_msg_done = 1'b0;
        chk("man_fan", 32'(fan_on), 1);
        chk("man_hum", 32'(hum_on), 0);
        chk("man_mode", 32'(manual_mode), 1);
        n = 0;
        while (manual_mode && n < 200) begin
            cyc();
            n++;
        end
        chk("man_timeout", 32'(manual_mode), 0);
        chk("man_duration", 32'(n >= (MS - 1) * T && n <= MS * T), 1);
        cyc();
        chk("auto_resume_hum", 32'(hum_on), 1);
        chk("auto_resume_fan", 32'(fan_on), 1);

        // Held rx_msg_done must not re-trigger
        do_reset();
        send("C", "8", "0");
        chk("held_first", 32'(max_hum), 80);
        chr_val0 = "9";
        pulses = 0;
        for (int i = 0; i < 999; i++) begin
            cyc();
            pulses += int'(cfg_err);
        end
        chk("held_max_hum", 32'(max_hum), 80);
        chk("held_no_err", 32'(pulses), 0);
        rx_msg_done = 1'b0;
        cyc();

        // Reset in the middle of an override
        send("L", "1", "1");
        rx_msg_done = 1'b0;
        cyc();
        chk("pre_rst_fan", 32'(fan_on), 1);
        rst = 1'b1;
        cyc();
        chk("rst_fan", 32'(fan_on), 0);
        chk("rst_hum", 32'(hum_on), 0);
        chk("rst_manual", 32'(manual_mode), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_min_hum", 32'(min_hum), 40);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rx_msg_done = ~rx_msg_done;
                if (!rx_msg_done) begin
                    chr_cmd = cmds[$urandom_range(0, 5)];
                    chr_val0 = vals[$urandom_range(0, 7)];
                    chr_val1 = vals[$urandom_range(0, 7)];
                end
            end
            if ($urandom_range(0, 15) == 0) temperature = 8'($urandom_range(0, 110));
            if ($urandom_range(0, 15) == 0) humidity = 8'($urandom_range(0, 110));
            rst = $urandom_range(0, 499) == 0;
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
